// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data memory responder: handshake FSM states and
// the wait-state counter width.
package data_mem_responder_pkg;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_GRANT
   } state_t;
endpackage

// File: rtl/data_mem_responder_if.sv
// Request/grant/response bus between an initiator and the data memory responder.
interface data_mem_responder_if;
   logic        req_i;
   logic        gnt_o;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;

   modport master (output req_i, we_i, be_i, addr_i, wdata_i,
                   input  gnt_o, rvalid_o, rdata_o, err_o);
   modport slave  (input  req_i, we_i, be_i, addr_i, wdata_i,
                   output gnt_o, rvalid_o, rdata_o, err_o);
endinterface

// File: rtl/data_mem_responder_byte_en_ram.sv
// Word-wide synchronous RAM with per-byte write enables; read data is
// registered on any enabled access.
module byte_en_ram #(
   parameter int    DEPTH       = 1024,
   parameter int    AW          = 10,
   parameter string MEMORY_FILE = ""
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         for (int b = 0; b < 4; b++)
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
   end
endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: req/gnt handshake with optional wait states,
// byte-enabled word memory, one-cycle registered response with range error.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int          MEMORY_SIZE = 4096,
   parameter string       MEMORY_FILE = "",
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          WAIT_STATES = 0,
   parameter int          WRITE_RESP  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_mem_responder_if.slave  bus
);
   localparam int DEPTH = MEMORY_SIZE / 4;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             gnt;
   logic             accept;
   logic [31:0]      offset;
   logic             in_range;
   logic             resp_n;
   logic             rvalid_q, err_q, rd_q;
   logic [31:0]      ram_rdata;

   assign offset   = bus.addr_i - BASE_ADDR;
   assign in_range = (bus.addr_i >= BASE_ADDR) && (offset < 32'(MEMORY_SIZE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      gnt     = 1'b0;
      case (state)
         ST_IDLE: begin
            // Zero wait states: grant follows req directly, but never during reset.
            if (WAIT_STATES == 0) begin
               gnt = bus.req_i && rst_n;
            end else if (bus.req_i) begin
               state_n = ST_WAIT;
               cnt_n   = CNT_W'(WAIT_STATES - 1);
            end
         end
         ST_WAIT: begin
            if (!bus.req_i) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else if (cnt == '0) begin
               state_n = ST_GRANT;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ST_GRANT: begin
            gnt     = bus.req_i;
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   assign bus.gnt_o = gnt;
   assign accept    = bus.req_i && gnt;

   // In-range writes are silent when write responses are disabled; errors always respond.
   assign resp_n = accept && (!bus.we_i || (WRITE_RESP != 0) || !in_range);

   byte_en_ram #(
      .DEPTH       (DEPTH),
      .AW          (AW),
      .MEMORY_FILE (MEMORY_FILE)
   ) u_ram (
      .clk   (clk),
      .en    (accept && in_range),
      .we    (bus.we_i ? bus.be_i : 4'b0000),
      .addr  (offset[AW+1:2]),
      .wdata (bus.wdata_i),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rd_q     <= 1'b0;
      end else begin
         rvalid_q <= resp_n;
         err_q    <= resp_n && !in_range;
         rd_q     <= accept && !bus.we_i && in_range;
      end
   end

   assign bus.rvalid_o = rvalid_q;
   assign bus.err_o    = err_q;
   assign bus.rdata_o  = rd_q ? ram_rdata : 32'h0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder over four configurations, with a
// scoreboard queue of expected responses checked on the falling edge.
module tb_data_mem_responder;
   typedef struct {
      int          id;
      logic [31:0] rdata;
      logic        err;
      longint      due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  gnt, rvalid;
   logic [31:0] rdata [4];
   logic        err [4];

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   exp_t   q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_responder_if bus0 ();
   data_mem_responder_if bus1 ();
   data_mem_responder_if bus2 ();
   data_mem_responder_if bus3 ();

   assign bus0.req_i = req[0]; assign bus0.we_i = we; assign bus0.be_i = be;
   assign bus0.addr_i = addr;  assign bus0.wdata_i = wdata;
   assign bus1.req_i = req[1]; assign bus1.we_i = we; assign bus1.be_i = be;
   assign bus1.addr_i = addr;  assign bus1.wdata_i = wdata;
   assign bus2.req_i = req[2]; assign bus2.we_i = we; assign bus2.be_i = be;
   assign bus2.addr_i = addr;  assign bus2.wdata_i = wdata;
   assign bus3.req_i = req[3]; assign bus3.we_i = we; assign bus3.be_i = be;
   assign bus3.addr_i = addr;  assign bus3.wdata_i = wdata;

   assign gnt    = {bus3.gnt_o, bus2.gnt_o, bus1.gnt_o, bus0.gnt_o};
   assign rvalid = {bus3.rvalid_o, bus2.rvalid_o, bus1.rvalid_o, bus0.rvalid_o};
   assign rdata[0] = bus0.rdata_o; assign err[0] = bus0.err_o;
   assign rdata[1] = bus1.rdata_o; assign err[1] = bus1.err_o;
   assign rdata[2] = bus2.rdata_o; assign err[2] = bus2.err_o;
   assign rdata[3] = bus3.rdata_o; assign err[3] = bus3.err_o;

   data_mem_responder #(.WAIT_STATES(0)) u_ws0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   data_mem_responder #(.WAIT_STATES(3)) u_ws3 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   data_mem_responder #(.WAIT_STATES(2)) u_ws2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   data_mem_responder #(.MEMORY_SIZE(64), .BASE_ADDR(32'h1000), .WAIT_STATES(0),
                        .WRITE_RESP(0)) u_nwr (.clk(clk), .rst_n(rst_n), .bus(bus3));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One transfer on port sel; waits returns the number of cycles gnt was low.
   task automatic xfer(input int sel, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic exp_resp, input logic [31:0] exp_rd,
                       input logic exp_err, output int waits);
      bit got = 1'b0;
      waits = 0;
      we = w; be = b; addr = a; wdata = d;
      req[sel] = 1'b1;
      while (!got && waits < 20) begin
         @(negedge clk);
         if (gnt[sel]) got = 1'b1;
         else waits++;
      end
      chk("gnt_timeout", 64'(got), 64'd1);
      if (got) begin
         if (exp_resp) q.push_back('{sel, exp_rd, exp_err, cyc + 1});
         @(posedge clk); #1;
      end
      req[sel] = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         if (rvalid[i]) begin
            if (q.size() == 0) begin
               chk("unexpected_rvalid", 64'(i), 64'hFFFF);
            end else begin
               e = q.pop_front();
               chk("resp_port", 64'(i), 64'(e.id));
               chk("resp_cycle", 64'(cyc), 64'(e.due));
               chk("resp_rdata", 64'(rdata[i]), 64'(e.rdata));
               chk("resp_err", 64'(err[i]), 64'(e.err));
            end
         end else begin
            chk("idle_zero", {31'h0, rdata[i], err[i]}, 64'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int  w;
      bit  seen;

      // Reset: grant must stay low even with requests raised.
      @(posedge clk); #1;
      req = 4'hF; #1;
      chk("rst_gnt", 64'(gnt), 64'h0);
      chk("rst_rvalid", 64'(rvalid), 64'h0);
      req = 4'h0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Zero wait states: back-to-back stream on port 0.
      xfer(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, w);
      chk("ws0_wr_wait", 64'(w), 64'd0);
      xfer(0, 0, 4'hF, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, w);
      chk("ws0_rd_wait", 64'(w), 64'd0);
      xfer(0, 1, 4'b0001, 32'h10, 32'h000000AA, 1, 32'h0, 0, w);
      xfer(0, 0, 4'h0, 32'h13, 32'h0, 1, 32'hDEADBEAA, 0, w);
      xfer(0, 0, 4'hF, 32'h1000, 32'h0, 1, 32'h0, 1, w);
      xfer(0, 1, 4'hF, 32'h1000, 32'h12345678, 1, 32'h0, 1, w);
      xfer(0, 0, 4'hF, 32'h0, 32'h0, 1, 32'h0, 0, w);
      xfer(0, 1, 4'b1100, 32'hFFC, 32'hCAFEF00D, 1, 32'h0, 0, w);
      xfer(0, 0, 4'hF, 32'hFFC, 32'h0, 1, 32'hCAFE0000, 0, w);
      repeat (2) @(posedge clk); #1;

      // Three wait states on port 1.
      xfer(1, 0, 4'hF, 32'h40, 32'h0, 1, 32'h0, 0, w);
      chk("ws3_rd_wait", 64'(w), 64'd4);
      xfer(1, 1, 4'hF, 32'h40, 32'hA5A5A5A5, 1, 32'h0, 0, w);
      chk("ws3_wr_wait", 64'(w), 64'd4);
      xfer(1, 0, 4'hF, 32'h40, 32'h0, 1, 32'hA5A5A5A5, 0, w);
      repeat (2) @(posedge clk); #1;

      // Two wait states: abandon the request after one cycle.
      seen = 1'b0;
      we = 1'b0; be = 4'hF; addr = 32'h0;
      req[2] = 1'b1;
      @(negedge clk); if (gnt[2]) seen = 1'b1;
      @(posedge clk); #1;
      req[2] = 1'b0;
      repeat (5) begin
         @(negedge clk); if (gnt[2]) seen = 1'b1;
      end
      chk("ws2_drop_gnt", 64'(seen), 64'd0);
      @(posedge clk); #1;
      xfer(2, 0, 4'hF, 32'h0, 32'h0, 1, 32'h0, 0, w);
      chk("ws2_fresh_wait", 64'(w), 64'd3);
      repeat (2) @(posedge clk); #1;

      // Reset while port 1 sits in WAIT.
      we = 1'b0; be = 4'hF; addr = 32'h40;
      req[1] = 1'b1;
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b0; #1;
      chk("rstw_gnt", 64'(gnt[1]), 64'd0);
      chk("rstw_rvalid", 64'(rvalid[1]), 64'd0);
      chk("rstw_rdata", 64'(rdata[1]), 64'd0);
      chk("rstw_err", 64'(err[1]), 64'd0);
      repeat (2) @(posedge clk); #1;
      chk("rstw_gnt_hold", 64'(gnt[1]), 64'd0);
      req[1] = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      xfer(1, 0, 4'hF, 32'h40, 32'h0, 1, 32'hA5A5A5A5, 0, w);
      chk("rstw_after_wait", 64'(w), 64'd4);
      repeat (2) @(posedge clk); #1;

      // Silent in-range writes, offset base, range edges on port 3.
      xfer(3, 1, 4'hF, 32'h1004, 32'h0BADF00D, 0, 32'h0, 0, w);
      xfer(3, 0, 4'hF, 32'h1004, 32'h0, 1, 32'h0BADF00D, 0, w);
      xfer(3, 1, 4'hF, 32'h0FFC, 32'h11111111, 1, 32'h0, 1, w);
      xfer(3, 1, 4'hF, 32'h1040, 32'h22222222, 1, 32'h0, 1, w);
      xfer(3, 0, 4'hF, 32'h103C, 32'h0, 1, 32'h0, 0, w);
      xfer(3, 0, 4'hF, 32'h1000, 32'h0, 1, 32'h0, 0, w);

      repeat (3) @(posedge clk); #1;
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
